// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, clog2 and parameter legality check for the sync FIFO
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - simple dual-port storage with one write port and a registered read port
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      re,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, read strobe and sticky errors
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc, wr_acc;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d  = (overflow_q  & ~clr_err) | (wr_en & ~wr_acc);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & ~rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_acc & ~rst),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];

    sync_fifo_param #(
        .DATA_W   (8),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected: got data 0x%0h expected no strobe", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        rst = 1'b0;

        // 1. reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);

        // 2. fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) begin
            step(1, 8'(i), 0, 0);
            check("fill_count", count, i);
            check("fill_almost_full", almost_full, (i >= 6));
            check("fill_full", full, (i == 8));
            check("fill_almost_empty", almost_empty, (i <= 2));
        end
        step(1, 8'hFF, 0, 0);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        step(0, 8'h00, 0, 1);
        check("ovf_clear", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            step(0, 8'h00, 1, 0);
            check("drain_rd_valid", rd_valid, 1);
        end
        step(0, 8'h00, 0, 0);
        check("drain_empty", empty, 1);
        check("drain_valid_drop", rd_valid, 0);

        // 3. underflow, clear, set-wins
        step(0, 8'h00, 1, 0);
        check("udf_rd_valid", rd_valid, 0);
        check("udf_rd_data_hold", rd_data, 8'h08);
        check("udf_flag", underflow, 1);
        step(0, 8'h00, 0, 1);
        check("udf_clear", underflow, 0);
        step(0, 8'h00, 1, 1);
        check("udf_set_wins", underflow, 1);
        step(0, 8'h00, 0, 1);

        // 4. simultaneous read+write when full
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0);
        exp_q.push_back(8'h10);
        step(1, 8'hA0, 1, 0);
        check("rw_full_count", count, 8);
        check("rw_full_full", full, 1);
        check("rw_full_overflow", overflow, 0);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'hA0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        check("rw_full_drained", empty, 1);

        // 5. simultaneous read+write when empty
        step(1, 8'h55, 1, 0);
        check("rw_empty_count", count, 1);
        check("rw_empty_underflow", underflow, 1);
        check("rw_empty_no_fallthrough", rd_valid, 0);
        step(0, 8'h00, 0, 1);
        exp_q.push_back(8'h55);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        check("rw_empty_after", empty, 1);

        // 6a. streaming with wrap-around against a reference queue
        begin
            int written;
            written = 0;
            for (int cyc = 0; cyc < 400 && (written < 20 || model_q.size() > 0); cyc++) begin
                logic w, r, racc, wacc;
                w = (written < 20) && ($urandom_range(0, 1) == 1);
                r = ($urandom_range(0, 1) == 1);
                racc = r && (model_q.size() > 0);
                wacc = w && ((model_q.size() < 8) || racc);
                if (racc) exp_q.push_back(model_q.pop_front());
                if (wacc) begin
                    model_q.push_back(8'(8'h30 + written));
                    written++;
                end
                step(w, 8'(8'h30 + written - (wacc ? 1 : 0)), r, 0);
                check("stream_count", count, model_q.size());
            end
            check("stream_all_written", written, 20);
            check("stream_model_empty", model_q.size(), 0);
        end
        step(0, 8'h00, 0, 1);

        // 6b. reset mid-stream discards contents
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
        check("pre_rst_count", count, 5);
        rst = 1'b1;
        step(0, 8'h00, 0, 0);
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        step(1, 8'hD1, 0, 0);
        exp_q.push_back(8'hD1);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        check("mid_rst_empty_after", empty, 1);

        step(0, 8'h00, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
